// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the relPrime multicycle controller.
//   state_t    - controller states (S_RESET is encoding 0)
//   OP_*       - opcode field values
//   CB_*       - bit positions of the fields inside the control word
//   ALU_*, PCSRC_* - field encodings
package mc_pkg;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_RWB      = 4'd4,
      S_EXEC_I   = 4'd5,
      S_IWB      = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WB   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_HALTED   = 4'd13,
      S_ILLEGAL  = 4'd14
   } state_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LW    = 4'h2;
   localparam logic [3:0] OP_SW    = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_BNE   = 4'h5;
   localparam logic [3:0] OP_J     = 4'h6;
   localparam logic [3:0] OP_JAL   = 4'h7;
   localparam logic [3:0] OP_HALT  = 4'h8;

   localparam int unsigned CTRL_BITS     = 16;
   localparam int unsigned CB_PCWRITE    = 15;
   localparam int unsigned CB_IRWRITE    = 14;
   localparam int unsigned CB_MEMREQ     = 13;
   localparam int unsigned CB_MEMWE      = 12;
   localparam int unsigned CB_IORD       = 11;
   localparam int unsigned CB_REGWRITE   = 10;
   localparam int unsigned CB_ALUSRCA    = 9;
   localparam int unsigned CB_ALUSRCB_LO = 7;   // 2 bits
   localparam int unsigned CB_ALUOP_LO   = 4;   // 3 bits
   localparam int unsigned CB_PCSRC_LO   = 2;   // 2 bits
   localparam int unsigned CB_MEMTOREG   = 1;
   localparam int unsigned CB_REGDST     = 0;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> datapath control word table.
//   state_i     current controller state
//   go_i        FETCH may issue its memory request (single-step gate)
//   mem_ready_i memory completes the current access this cycle
//   zero_i      ALU zero flag (BRANCH)
//   is_bne_i    opcode is BNE (inverts branch sense)
//   is_jal_i    opcode is JAL (link write in JUMP)
//   ctrl_o      control word, field layout from mc_pkg
module mc_ctrl_decode
   import mc_pkg::*;
#(
   parameter int unsigned CTRL_W = 16
) (
   input  state_t              state_i,
   input  logic                go_i,
   input  logic                mem_ready_i,
   input  logic                zero_i,
   input  logic                is_bne_i,
   input  logic                is_jal_i,
   output logic [CTRL_W-1:0]   ctrl_o
);

   logic [CTRL_BITS-1:0] w;

   always_comb begin
      w = '0;
      case (state_i)
         S_FETCH: begin
            if (go_i) begin
               w[CB_MEMREQ]              = 1'b1;
               w[CB_ALUSRCB_LO +: 2]     = 2'b01;
               w[CB_ALUOP_LO +: 3]       = ALU_ADD;
               w[CB_PCSRC_LO +: 2]       = PCSRC_ALU;
               // IR load and PC+1 only on the completing cycle
               w[CB_IRWRITE]             = mem_ready_i;
               w[CB_PCWRITE]             = mem_ready_i;
            end
         end
         S_DECODE: begin
            w[CB_ALUSRCB_LO +: 2] = 2'b11;
            w[CB_ALUOP_LO +: 3]   = ALU_ADD;
         end
         S_EXEC_R: begin
            w[CB_ALUSRCA]         = 1'b1;
            w[CB_ALUOP_LO +: 3]   = ALU_FUNCT;
         end
         S_RWB: begin
            w[CB_REGWRITE] = 1'b1;
            w[CB_REGDST]   = 1'b1;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            w[CB_ALUSRCA]         = 1'b1;
            w[CB_ALUSRCB_LO +: 2] = 2'b10;
            w[CB_ALUOP_LO +: 3]   = ALU_ADD;
         end
         S_IWB: begin
            w[CB_REGWRITE] = 1'b1;
         end
         S_MEM_RD: begin
            w[CB_MEMREQ] = 1'b1;
            w[CB_IORD]   = 1'b1;
         end
         S_MEM_WB: begin
            w[CB_MEMTOREG] = 1'b1;
            w[CB_REGWRITE] = 1'b1;
         end
         S_MEM_WR: begin
            // MemWE is a qualifier of the request, held for the whole access
            w[CB_MEMREQ] = 1'b1;
            w[CB_MEMWE]  = 1'b1;
            w[CB_IORD]   = 1'b1;
         end
         S_BRANCH: begin
            w[CB_ALUSRCA]         = 1'b1;
            w[CB_ALUOP_LO +: 3]   = ALU_SUB;
            w[CB_PCSRC_LO +: 2]   = PCSRC_TARGET;
            w[CB_PCWRITE]         = zero_i ^ is_bne_i;
         end
         S_JUMP: begin
            w[CB_PCWRITE]         = 1'b1;
            w[CB_PCSRC_LO +: 2]   = PCSRC_JUMP;
            w[CB_REGWRITE]        = is_jal_i;
         end
         default: w = '0;
      endcase
   end

   assign ctrl_o = CTRL_W'(w);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit for the 16-bit relPrime datapath.
//   CLK, RST_N     clock; asynchronous active-low reset
//   opcode         IR opcode field, stable from DECODE onwards
//   zero           ALU zero flag, used in BRANCH
//   mem_ready      memory completes the current access this cycle
//   dbg_step_mode  pause in FETCH until dbg_step
//   dbg_step       one-cycle pulse releasing one instruction
//   ctrl           datapath control word
//   current_state  registered state, next_state combinational next state
//   halted         high in HALTED; illegal sticky undefined-opcode flag
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int unsigned OPC_W   = 4,
   parameter int unsigned STATE_W = 5,
   parameter int unsigned CTRL_W  = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               zero,
   input  logic               mem_ready,
   input  logic               dbg_step_mode,
   input  logic               dbg_step,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [STATE_W-1:0] current_state,
   output logic [STATE_W-1:0] next_state,
   output logic               halted,
   output logic               illegal
);

   state_t state_q, state_d;
   logic   step_q, step_d;
   logic   illegal_q, illegal_d;
   logic   go;

   logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_halt;

   assign is_r    = (opcode == OPC_W'(OP_RTYPE));
   assign is_addi = (opcode == OPC_W'(OP_ADDI));
   assign is_lw   = (opcode == OPC_W'(OP_LW));
   assign is_sw   = (opcode == OPC_W'(OP_SW));
   assign is_beq  = (opcode == OPC_W'(OP_BEQ));
   assign is_bne  = (opcode == OPC_W'(OP_BNE));
   assign is_j    = (opcode == OPC_W'(OP_J));
   assign is_jal  = (opcode == OPC_W'(OP_JAL));
   assign is_halt = (opcode == OPC_W'(OP_HALT));

   // A step seen in FETCH stays armed until that fetch completes
   assign go = ~dbg_step_mode | step_q | dbg_step;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:    state_d = S_FETCH;
         S_FETCH:    if (go && mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (is_r)                  state_d = S_EXEC_R;
            else if (is_addi)          state_d = S_EXEC_I;
            else if (is_lw || is_sw)   state_d = S_MEM_ADDR;
            else if (is_beq || is_bne) state_d = S_BRANCH;
            else if (is_j || is_jal)   state_d = S_JUMP;
            else if (is_halt)          state_d = S_HALTED;
            else                       state_d = S_ILLEGAL;
         end
         S_EXEC_R:   state_d = S_RWB;
         S_RWB:      state_d = S_FETCH;
         S_EXEC_I:   state_d = S_IWB;
         S_IWB:      state_d = S_FETCH;
         S_MEM_ADDR: state_d = is_lw ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:   state_d = S_FETCH;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_HALTED:   state_d = S_HALTED;
         S_ILLEGAL:  state_d = S_HALTED;
         default:    state_d = S_RESET;
      endcase

      step_d    = (state_q == S_FETCH) && (state_d == S_FETCH) && (step_q || dbg_step);
      illegal_d = illegal_q || (state_d == S_ILLEGAL);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_RESET;
         step_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         illegal_q <= illegal_d;
      end
   end

   mc_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
      .state_i     (state_q),
      .go_i        (go),
      .mem_ready_i (mem_ready),
      .zero_i      (zero),
      .is_bne_i    (is_bne),
      .is_jal_i    (is_jal),
      .ctrl_o      (ctrl)
   );

   assign current_state = STATE_W'(state_q);
   assign next_state    = STATE_W'(state_d);
   assign halted        = (state_q == S_HALTED);
   assign illegal       = illegal_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction-level bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;
   import mc_pkg::*;

   logic        CLK, RST_N;
   logic [3:0]  opcode;
   logic        zero, mem_ready, dbg_step_mode, dbg_step;
   logic [15:0] ctrl;
   logic [4:0]  current_state, next_state;
   logic        halted, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [4:0] T_RESET   = 5'(S_RESET);
   localparam logic [4:0] T_FETCH   = 5'(S_FETCH);
   localparam logic [4:0] T_DECODE  = 5'(S_DECODE);
   localparam logic [4:0] T_EXEC_R  = 5'(S_EXEC_R);
   localparam logic [4:0] T_RWB     = 5'(S_RWB);
   localparam logic [4:0] T_MEM_WR  = 5'(S_MEM_WR);
   localparam logic [4:0] T_HALTED  = 5'(S_HALTED);
   localparam logic [4:0] T_ILLEGAL = 5'(S_ILLEGAL);

   mc_ctrl_fsm #(.OPC_W(4), .STATE_W(5), .CTRL_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step), .ctrl(ctrl),
      .current_state(current_state), .next_state(next_state), .halted(halted), .illegal(illegal)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- instruction-level reference model ----------------
   function automatic int m_cycles(logic [3:0] op, int fw, int mw);
      if (op == OP_RTYPE || op == OP_ADDI) return 4 + fw;
      if (op == OP_LW) return 5 + fw + mw;
      if (op == OP_SW) return 4 + fw + mw;
      return 3 + fw;
   endfunction
   function automatic int m_regw(logic [3:0] op);
      return (op == OP_RTYPE || op == OP_ADDI || op == OP_LW || op == OP_JAL) ? 1 : 0;
   endfunction
   function automatic int m_pcw(logic [3:0] op, logic z);
      int n = 1;
      if (op == OP_BEQ && z) n++;
      if (op == OP_BNE && !z) n++;
      if (op == OP_J || op == OP_JAL) n++;
      return n;
   endfunction
   function automatic logic [1:0] m_pcsrc(logic [3:0] op, logic z);
      if ((op == OP_BEQ && z) || (op == OP_BNE && !z)) return 2'b01;
      if (op == OP_J || op == OP_JAL) return 2'b10;
      return 2'b00;
   endfunction
   function automatic int m_memwe(logic [3:0] op, int mw);
      return (op == OP_SW) ? 1 + mw : 0;
   endfunction
   function automatic int m_stall(logic [3:0] op, int fw, int mw);
      return fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
   endfunction

   // Runs one instruction from a FETCH cycle (entered at a negedge) back to the
   // next FETCH. A memory responder answers the n-th access after its wait count.
   task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw,
                            output int cyc, output int irw, output int rw, output int pcw,
                            output int mwe, output int stl, output int nsbad, output int sbad,
                            output logic [1:0] ps, output logic [7:0][4:0] seq, output bit tmo);
      int cnt;
      bit left;
      cyc = 0; irw = 0; rw = 0; pcw = 0; mwe = 0; stl = 0; nsbad = 0; sbad = 0;
      ps = 2'b00; seq = '0; tmo = 1'b1; left = 1'b0; cnt = fw;
      opcode = op; zero = z;
      for (int k = 0; k < 300; k++) begin
         if (k > 0) @(negedge CLK);
         if (left && current_state == T_FETCH) begin
            tmo = 1'b0;
            break;
         end
         if (current_state != T_FETCH) left = 1'b1;
         if (ctrl[CB_MEMREQ]) mem_ready = (cnt == 0);
         else                 mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (cyc < 8) seq[cyc] = current_state;
         cyc++;
         irw += int'(ctrl[CB_IRWRITE]);
         rw  += int'(ctrl[CB_REGWRITE]);
         pcw += int'(ctrl[CB_PCWRITE]);
         mwe += int'(ctrl[CB_MEMWE]);
         if (ctrl[CB_MEMREQ] && !mem_ready) begin
            stl++;
            cnt--;
            if (next_state !== current_state) nsbad++;
            if (ctrl[CB_PCWRITE] || ctrl[CB_IRWRITE] || ctrl[CB_REGWRITE]) sbad++;
         end else if (ctrl[CB_MEMREQ] && mem_ready) begin
            cnt = mw;
         end
         if (ctrl[CB_PCWRITE] && !ctrl[CB_IRWRITE]) ps = ctrl[CB_PCSRC_LO +: 2];
      end
   endtask

   task automatic apply_reset();
      mem_ready = 1'b0; dbg_step = 1'b0; dbg_step_mode = 1'b0;
      RST_N = 1'b0;
      #2;
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST_N = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      dbg_step_mode = 1'b0; dbg_step = 1'b0;
      #3;
      n_checks++; if (current_state !== T_RESET) begin n_fail++; $display("FAIL reset_state got %0d want %0d", current_state, T_RESET); end
      n_checks++; if (ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0000", ctrl); end
      n_checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_flags got halted=%b illegal=%b want 0 0", halted, illegal); end
      @(negedge CLK); @(negedge CLK);
      RST_N = 1'b1;
      #1;
      n_checks++; if (current_state !== T_RESET) begin n_fail++; $display("FAIL release_state got %0d want %0d", current_state, T_RESET); end
      @(negedge CLK);
      n_checks++; if (current_state !== T_FETCH) begin n_fail++; $display("FAIL first_edge got %0d want %0d", current_state, T_FETCH); end
   endtask

   task automatic test_add();
      int cyc, irw, rw, pcw, mwe, stl, nsbad, sbad; logic [1:0] ps; logic [7:0][4:0] seq; bit tmo;
      logic [19:0] exp_seq;
      exp_seq = {T_RWB, T_EXEC_R, T_DECODE, T_FETCH};
      run_instr(OP_RTYPE, 1'b0, 0, 0, cyc, irw, rw, pcw, mwe, stl, nsbad, sbad, ps, seq, tmo);
      n_checks++; if (tmo || cyc !== 4) begin n_fail++; $display("FAIL add_cycles got %0d (timeout=%0b) want 4", cyc, tmo); end
      n_checks++; if (seq[3:0] !== exp_seq) begin n_fail++; $display("FAIL add_sequence got %h want %h", seq[3:0], exp_seq); end
      n_checks++; if (rw !== 1 || irw !== 1) begin n_fail++; $display("FAIL add_pulses got regwrite=%0d irwrite=%0d want 1 1", rw, irw); end
   endtask

   task automatic test_lw_waits();
      int cyc, irw, rw, pcw, mwe, stl, nsbad, sbad; logic [1:0] ps; logic [7:0][4:0] seq; bit tmo;
      run_instr(OP_LW, 1'b0, 3, 2, cyc, irw, rw, pcw, mwe, stl, nsbad, sbad, ps, seq, tmo);
      n_checks++; if (tmo || cyc !== 10) begin n_fail++; $display("FAIL lw_cycles got %0d (timeout=%0b) want 10", cyc, tmo); end
      n_checks++; if (irw !== 1 || rw !== 1) begin n_fail++; $display("FAIL lw_pulses got irwrite=%0d regwrite=%0d want 1 1", irw, rw); end
      n_checks++; if (stl !== 5 || nsbad !== 0) begin n_fail++; $display("FAIL lw_stall got stalls=%0d next_changed=%0d want 5 0", stl, nsbad); end
      n_checks++; if (sbad !== 0) begin n_fail++; $display("FAIL lw_strobe_in_wait got %0d want 0", sbad); end
   endtask

   task automatic test_branch();
      int cyc, irw, rw, pcw, mwe, stl, nsbad, sbad; logic [1:0] ps; logic [7:0][4:0] seq; bit tmo;
      run_instr(OP_BEQ, 1'b1, 0, 0, cyc, irw, rw, pcw, mwe, stl, nsbad, sbad, ps, seq, tmo);
      n_checks++; if (tmo || pcw !== m_pcw(OP_BEQ, 1'b1) || ps !== 2'b01) begin n_fail++; $display("FAIL beq_taken got pcwrite=%0d pcsrc=%b want %0d 01", pcw, ps, m_pcw(OP_BEQ, 1'b1)); end
      run_instr(OP_BNE, 1'b1, 0, 0, cyc, irw, rw, pcw, mwe, stl, nsbad, sbad, ps, seq, tmo);
      n_checks++; if (tmo || pcw !== m_pcw(OP_BNE, 1'b1)) begin n_fail++; $display("FAIL bne_not_taken got pcwrite=%0d want %0d", pcw, m_pcw(OP_BNE, 1'b1)); end
   endtask

   task automatic test_random();
      int cyc, irw, rw, pcw, mwe, stl, nsbad, sbad; logic [1:0] ps; logic [7:0][4:0] seq; bit tmo;
      logic [3:0] op; logic z; int fw, mw;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 7));
         z  = 1'($urandom_range(0, 1));
         fw = int'($urandom_range(0, 3));
         mw = int'($urandom_range(0, 3));
         run_instr(op, z, fw, mw, cyc, irw, rw, pcw, mwe, stl, nsbad, sbad, ps, seq, tmo);
         n_checks++; if (tmo || cyc !== m_cycles(op, fw, mw)) begin n_fail++; $display("FAIL rnd%0d_cycles op=%h got %0d want %0d", i, op, cyc, m_cycles(op, fw, mw)); end
         n_checks++; if (irw !== 1) begin n_fail++; $display("FAIL rnd%0d_irwrite op=%h got %0d want 1", i, op, irw); end
         n_checks++; if (rw !== m_regw(op)) begin n_fail++; $display("FAIL rnd%0d_regwrite op=%h got %0d want %0d", i, op, rw, m_regw(op)); end
         n_checks++; if (pcw !== m_pcw(op, z) || ps !== m_pcsrc(op, z)) begin n_fail++; $display("FAIL rnd%0d_pc op=%h z=%b got pcwrite=%0d pcsrc=%b want %0d %b", i, op, z, pcw, ps, m_pcw(op, z), m_pcsrc(op, z)); end
         n_checks++; if (mwe !== m_memwe(op, mw)) begin n_fail++; $display("FAIL rnd%0d_memwe op=%h got %0d want %0d", i, op, mwe, m_memwe(op, mw)); end
         n_checks++; if (stl !== m_stall(op, fw, mw) || nsbad !== 0 || sbad !== 0) begin n_fail++; $display("FAIL rnd%0d_stall op=%h got stalls=%0d next_changed=%0d strobes=%0d want %0d 0 0", i, op, stl, nsbad, sbad, m_stall(op, fw, mw)); end
      end
   endtask

   task automatic test_single_step();
      int bad, cyc;
      bad = 0; cyc = 1;
      dbg_step_mode = 1'b1; opcode = OP_RTYPE; mem_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (current_state !== T_FETCH || ctrl[CB_MEMREQ] !== 1'b0) bad++;
         @(negedge CLK);
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL step_hold got %0d bad cycles want 0", bad); end
      dbg_step = 1'b1;
      #1;
      n_checks++; if (ctrl[CB_MEMREQ] !== 1'b1) begin n_fail++; $display("FAIL step_release got memreq=%b want 1", ctrl[CB_MEMREQ]); end
      @(negedge CLK);
      for (int k = 0; k < 20; k++) begin
         if (current_state === T_FETCH) break;
         dbg_step = 1'($urandom_range(0, 1));   // steps outside FETCH must be ignored
         cyc++;
         @(negedge CLK);
      end
      dbg_step = 1'b0;
      n_checks++; if (cyc !== 4 || current_state !== T_FETCH) begin n_fail++; $display("FAIL step_instr got %0d cycles state=%0d want 4 %0d", cyc, current_state, T_FETCH); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (current_state !== T_FETCH || ctrl[CB_MEMREQ] !== 1'b0) bad++;
         @(negedge CLK);
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL step_rearm got %0d bad cycles want 0", bad); end
      dbg_step_mode = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      opcode = OP_SW; mem_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (current_state === T_MEM_WR) break;
         @(negedge CLK);
      end
      mem_ready = 1'b0;
      @(negedge CLK);
      #2;
      n_checks++; if (current_state !== T_MEM_WR || ctrl[CB_MEMREQ] !== 1'b1) begin n_fail++; $display("FAIL midwr_setup got state=%0d memreq=%b want %0d 1", current_state, ctrl[CB_MEMREQ], T_MEM_WR); end
      RST_N = 1'b0;
      #1;
      n_checks++; if (ctrl !== 16'h0 || current_state !== T_RESET) begin n_fail++; $display("FAIL midwr_async got ctrl=%h state=%0d want 0000 0", ctrl, current_state); end
      @(negedge CLK);
      #2;
      RST_N = 1'b1;
      #1;
      n_checks++; if (current_state !== T_RESET) begin n_fail++; $display("FAIL midwr_release got %0d want 0", current_state); end
      @(negedge CLK);
      n_checks++; if (current_state !== T_FETCH) begin n_fail++; $display("FAIL midwr_refetch got %0d want %0d", current_state, T_FETCH); end
   endtask

   task automatic test_illegal();
      int bad;
      bad = 0;
      opcode = 4'hF; mem_ready = 1'b1;
      @(negedge CLK);
      n_checks++; if (current_state !== T_DECODE || illegal !== 1'b0) begin n_fail++; $display("FAIL ill_decode got state=%0d illegal=%b want %0d 0", current_state, illegal, T_DECODE); end
      @(negedge CLK);
      n_checks++; if (current_state !== T_ILLEGAL || illegal !== 1'b1 || ctrl !== 16'h0) begin n_fail++; $display("FAIL ill_trap got state=%0d illegal=%b ctrl=%h want %0d 1 0000", current_state, illegal, ctrl, T_ILLEGAL); end
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         mem_ready = 1'($urandom_range(0, 1));
         dbg_step  = 1'($urandom_range(0, 1));
         #1;
         if (current_state !== T_HALTED || halted !== 1'b1 || ctrl !== 16'h0 || illegal !== 1'b1) bad++;
      end
      dbg_step = 1'b0;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ill_halted got %0d bad cycles want 0", bad); end
      apply_reset();
      n_checks++; if (illegal !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL ill_reset got illegal=%b halted=%b want 0 0", illegal, halted); end
   endtask

   task automatic test_halt();
      opcode = OP_HALT; mem_ready = 1'b1;
      @(negedge CLK); @(negedge CLK);
      for (int k = 0; k < 5; k++) @(negedge CLK);
      n_checks++; if (halted !== 1'b1 || illegal !== 1'b0 || ctrl !== 16'h0 || current_state !== T_HALTED) begin n_fail++; $display("FAIL halt got halted=%b illegal=%b ctrl=%h state=%0d want 1 0 0000 %0d", halted, illegal, ctrl, current_state, T_HALTED); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_waits();
      test_branch();
      test_random();
      test_single_step();
      test_reset_mid_write();
      test_illegal();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
